// File: rtl/register_file_sb.sv
// Multi-port register file with per-register busy scoreboard for RAW hazard detection.
// Reads are combinational (zero latency); writes, issues and pending_count update on the rising edge.
module register_file_sb #(
    parameter int WIDTH     = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    localparam int AW = $clog2(NUM_REGS),
    localparam int CW = $clog2(NUM_REGS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_READ*AW-1:0]     read_addr,
    output logic [NUM_READ*WIDTH-1:0]  read_data,
    output logic [NUM_READ-1:0]        read_busy,
    input  logic [NUM_WRITE-1:0]       write_en,
    input  logic [NUM_WRITE*AW-1:0]    write_addr,
    input  logic [NUM_WRITE*WIDTH-1:0] write_data,
    input  logic                       issue_en,
    input  logic [AW-1:0]              issue_addr,
    output logic [CW-1:0]              pending_count
);

    localparam logic [AW:0] NR = (AW + 1)'(NUM_REGS);

    logic [WIDTH-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [CW-1:0]       r_pending;

    logic [NUM_REGS-1:0] w_wr_hit;
    logic [WIDTH-1:0]    w_wr_dat [NUM_REGS];
    logic [NUM_REGS-1:0] w_iss_hit;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [CW-1:0]       w_cnt;

    function automatic logic f_in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < NR);
    endfunction

    function automatic logic f_is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Address targets a real, writable register
    function automatic logic f_writable(input logic [AW-1:0] a);
        return f_in_range(a) && !f_is_zero(a);
    endfunction

    // Ascending port scan so the highest enabled port index wins a conflict
    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_dat[i] = '0;
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (write_en[j] && f_writable(write_addr[j*AW +: AW]) &&
                    (write_addr[j*AW +: AW] == AW'(i))) begin
                    w_wr_hit[i] = 1'b1;
                    w_wr_dat[i] = write_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_iss_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_en && f_writable(issue_addr) && (issue_addr == AW'(i))) begin
                w_iss_hit[i] = 1'b1;
            end
        end
    end

    // Issue is younger than a same-cycle writeback, so it wins on busy
    always_comb begin
        w_busy_nxt = (r_busy & ~w_wr_hit) | w_iss_hit;
        w_cnt      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt = w_cnt + CW'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= w_wr_dat[i];
                end
            end
            r_busy    <= w_busy_nxt;
            r_pending <= w_cnt;
        end
    end

    assign pending_count = r_pending;

    // Read mux: register array, then bypass, then zero/out-of-range forcing
    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (read_addr[p*AW +: AW] == AW'(i)) begin
                    read_data[p*WIDTH +: WIDTH] = r_regs[i];
                    read_busy[p]                = r_busy[i];
                end
            end
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WRITE; j++) begin
                    if (write_en[j] && (write_addr[j*AW +: AW] == read_addr[p*AW +: AW])) begin
                        read_data[p*WIDTH +: WIDTH] = write_data[j*WIDTH +: WIDTH];
                        read_busy[p]                = 1'b0;
                    end
                end
            end
            if (!f_in_range(read_addr[p*AW +: AW]) || f_is_zero(read_addr[p*AW +: AW])) begin
                read_data[p*WIDTH +: WIDTH] = '0;
                read_busy[p]                = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: dut_a (bypass, zero reg), dut_b (no bypass), dut_c (20 regs, no zero reg) share stimulus.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  read_addr;
    logic [1:0]  write_en;
    logic [9:0]  write_addr;
    logic [63:0] write_data;
    logic        issue_en;
    logic [4:0]  issue_addr;

    logic [63:0] rd_a, rd_b, rd_c;
    logic [1:0]  bz_a, bz_b, bz_c;
    logic [5:0]  pc_a, pc_b;
    logic [4:0]  pc_c;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    register_file_sb #(.BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .read_addr(read_addr), .read_data(rd_a), .read_busy(bz_a),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .pending_count(pc_a));

    register_file_sb #(.BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset), .read_addr(read_addr), .read_data(rd_b), .read_busy(bz_b),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .pending_count(pc_b));

    register_file_sb #(.NUM_REGS(20), .BYPASS(1), .ZERO_REG(0)) dut_c (
        .clk(clk), .reset(reset), .read_addr(read_addr), .read_data(rd_c), .read_busy(bz_c),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .pending_count(pc_c));

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic ie, input logic [4:0] ia,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        write_en   = we;
        write_addr = {wa1, wa0};
        write_data = {wd1, wd0};
        issue_en   = ie;
        issue_addr = ia;
        read_addr  = {ra1, ra0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1'b1, 5'd6, 0, 0);
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'(i), 5'(31 - i));
            vecs++;
            if (rd_a !== 64'd0 || bz_a !== 2'b00 || rd_b !== 64'd0 || bz_b !== 2'b00 ||
                rd_c !== 64'd0 || bz_c !== 2'b00) begin
                errs++;
                $display("FAIL reset_read addr=%0d: a=%h/%b b=%h/%b c=%h/%b, want all 0",
                         i, rd_a, bz_a, rd_b, bz_b, rd_c, bz_c);
            end
        end
        vecs++;
        if (pc_a !== 6'd0 || pc_b !== 6'd0 || pc_c !== 5'd0) begin
            errs++;
            $display("FAIL reset_pending: a=%0d b=%0d c=%0d, want 0", pc_a, pc_b, pc_c);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd1, 32'h0, 1'b0, 0, 5'd1, 5'd5);
        vecs++;
        if (rd_a[63:32] !== 32'hDEADBEEF || rd_b[63:32] !== 32'h0) begin
            errs++;
            $display("FAIL wr_same_cycle: bypass=%h want deadbeef, nobypass=%h want 0",
                     rd_a[63:32], rd_b[63:32]);
        end
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd0, 5'd5);
        vecs++;
        if (rd_a[63:32] !== 32'hDEADBEEF || rd_b[63:32] !== 32'hDEADBEEF ||
            rd_c[63:32] !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL wr_next_cycle: a=%h b=%h c=%h want deadbeef",
                     rd_a[63:32], rd_b[63:32], rd_c[63:32]);
        end
    endtask

    task automatic test_conflict();
        drive(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 0, 5'd7, 5'd5);
        vecs++;
        if (rd_a[31:0] !== 32'h22 || rd_b[31:0] !== 32'h0) begin
            errs++;
            $display("FAIL conflict_bypass: a=%h want 22, b=%h want 0", rd_a[31:0], rd_b[31:0]);
        end
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd5, 5'd7);
        vecs++;
        if (rd_a[63:32] !== 32'h22 || rd_b[63:32] !== 32'h22 || rd_c[63:32] !== 32'h22) begin
            errs++;
            $display("FAIL conflict_stored: a=%h b=%h c=%h want 22",
                     rd_a[63:32], rd_b[63:32], rd_c[63:32]);
        end
    endtask

    task automatic test_zero_reg();
        drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd1, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        vecs++;
        if (rd_a[31:0] !== 32'h0 || bz_a[0] !== 1'b0 || rd_c[31:0] !== 32'hFFFFFFFF) begin
            errs++;
            $display("FAIL zero_same_cycle: a=%h/%b want 0/0, c=%h want ffffffff",
                     rd_a[31:0], bz_a[0], rd_c[31:0]);
        end
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd0, 5'd0);
        vecs++;
        if (rd_a[31:0] !== 32'h0 || bz_a[0] !== 1'b0 || pc_a !== 6'd0 ||
            rd_b[31:0] !== 32'h0 || pc_b !== 6'd0) begin
            errs++;
            $display("FAIL zero_reg: a=%h busy=%b pc=%0d b=%h pc=%0d, want 0",
                     rd_a[31:0], bz_a[0], pc_a, rd_b[31:0], pc_b);
        end
        vecs++;
        if (rd_c[31:0] !== 32'hFFFFFFFF || bz_c[0] !== 1'b1 || pc_c !== 5'd1) begin
            errs++;
            $display("FAIL nonzero_reg0: c=%h busy=%b pc=%0d, want ffffffff/1/1",
                     rd_c[31:0], bz_c[0], pc_c);
        end
    endtask

    task automatic test_scoreboard();
        drive(2'b00, 0, 0, 0, 0, 1'b1, 5'd3, 5'd3, 5'd9);
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b1, 5'd9, 5'd3, 5'd9);
        vecs++;
        if (bz_a !== 2'b01 || pc_a !== 6'd1 || pc_c !== 5'd2) begin
            errs++;
            $display("FAIL issue3: busy=%b want 01, pc_a=%0d want 1, pc_c=%0d want 2", bz_a, pc_a, pc_c);
        end
        tick();
        drive(2'b01, 5'd3, 32'h33, 5'd1, 32'h0, 1'b0, 0, 5'd3, 5'd9);
        vecs++;
        if (pc_a !== 6'd2 || pc_c !== 5'd3 || bz_a !== 2'b10 || bz_b !== 2'b11) begin
            errs++;
            $display("FAIL issue9: pc_a=%0d want 2, pc_c=%0d want 3, busy_a=%b want 10, busy_b=%b want 11",
                     pc_a, pc_c, bz_a, bz_b);
        end
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd3, 5'd9);
        vecs++;
        if (bz_a !== 2'b10 || bz_b !== 2'b10 || pc_a !== 6'd1 || pc_b !== 6'd1 ||
            pc_c !== 5'd2 || rd_a[31:0] !== 32'h33) begin
            errs++;
            $display("FAIL write3_clear: busy=%b/%b want 10, pc=%0d/%0d want 1, pc_c=%0d want 2, d=%h want 33",
                     bz_a, bz_b, pc_a, pc_b, pc_c, rd_a[31:0]);
        end
    endtask

    task automatic test_issue_write_same();
        drive(2'b10, 5'd1, 32'h0, 5'd4, 32'h55, 1'b1, 5'd4, 5'd4, 5'd4);
        vecs++;
        if (rd_a[31:0] !== 32'h55 || bz_a[0] !== 1'b0 || rd_b[31:0] !== 32'h0 || bz_b[0] !== 1'b0) begin
            errs++;
            $display("FAIL iw_same_cycle: a=%h/%b want 55/0, b=%h/%b want 0/0",
                     rd_a[31:0], bz_a[0], rd_b[31:0], bz_b[0]);
        end
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b1, 5'd4, 5'd4, 5'd4);
        vecs++;
        if (rd_a[31:0] !== 32'h55 || bz_a[0] !== 1'b1 || rd_b[31:0] !== 32'h55 ||
            pc_a !== 6'd2 || pc_c !== 5'd3) begin
            errs++;
            $display("FAIL iw_after: a=%h busy=%b b=%h pc_a=%0d pc_c=%0d, want 55/1/55/2/3",
                     rd_a[31:0], bz_a[0], rd_b[31:0], pc_a, pc_c);
        end
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd4, 5'd9);
        vecs++;
        if (pc_a !== 6'd2 || bz_a !== 2'b11) begin
            errs++;
            $display("FAIL reissue_busy: pc=%0d want 2, busy=%b want 11", pc_a, bz_a);
        end
    endtask

    task automatic test_out_of_range();
        drive(2'b01, 5'd25, 32'hABCD, 5'd1, 32'h0, 1'b1, 5'd25, 5'd25, 5'd25);
        vecs++;
        if (rd_c !== 64'd0 || bz_c !== 2'b00 || rd_a[31:0] !== 32'hABCD) begin
            errs++;
            $display("FAIL oor_same_cycle: c=%h/%b want 0/00, a=%h want abcd", rd_c, bz_c, rd_a[31:0]);
        end
        tick();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd25, 5'd25);
        vecs++;
        if (rd_c !== 64'd0 || bz_c !== 2'b00 || pc_c !== 5'd3 ||
            pc_a !== 6'd3 || bz_a !== 2'b11 || rd_a[31:0] !== 32'hABCD) begin
            errs++;
            $display("FAIL oor_after: c=%h/%b pc_c=%0d want 0/00/3, a=%h/%b pc_a=%0d want abcd/11/3",
                     rd_c, bz_c, pc_c, rd_a[31:0], bz_a, pc_a);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        drive(2'b01, 5'd12, 32'h77, 5'd1, 32'h0, 1'b1, 5'd12, 5'd12, 5'd4);
        tick();
        reset = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5'd12, 5'd4);
        vecs++;
        if (pc_a !== 6'd0 || pc_b !== 6'd0 || pc_c !== 5'd0 || bz_a !== 2'b00 ||
            bz_c !== 2'b00 || rd_a !== 64'd0 || rd_c !== 64'd0) begin
            errs++;
            $display("FAIL mid_reset: pc=%0d/%0d/%0d busy=%b/%b a=%h c=%h, want all 0",
                     pc_a, pc_b, pc_c, bz_a, bz_c, rd_a, rd_c);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        test_reset();
        test_write_read();
        tick();
        test_conflict();
        tick();
        test_zero_reg();
        tick();
        test_scoreboard();
        tick();
        test_issue_write_same();
        tick();
        test_out_of_range();
        tick();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
